// File: rtl/l2mc_pkg.sv
// Shared types and constants for the L2 miss sequencer.
// The GAP state exists only when L2MC_RETRY_EN is defined.
package l2mc_pkg;

  localparam int DW_DEF = 128;
  localparam int AW_DEF = 3;
  localparam int CW_DEF = 8;

  localparam logic [DW_DEF-1:0] BUS_Z = {DW_DEF{1'bz}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RD,
    ST_CAP,
    ST_RSP
`ifdef L2MC_RETRY_EN
    , ST_GAP
`endif
  } l2mc_state_e;

endpackage

// File: rtl/l2_miss_ctrl_if.sv
// L2-side request/fill handshake bundle; master is the L2 cache, slave is the miss sequencer.
interface l2_miss_ctrl_if #(
  parameter int DW = 128,
  parameter int AW = 3
);
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_group;
  logic          req_dirty;
  logic [DW-1:0] req_wdata;
  logic          fill_valid;
  logic          fill_ready;
  logic [DW-1:0] fill_data;
  logic          fill_err;

  modport master (
    output req_valid, req_group, req_dirty, req_wdata, fill_ready,
    input  req_ready, fill_valid, fill_data, fill_err
  );

  modport slave (
    input  req_valid, req_group, req_dirty, req_wdata, fill_ready,
    output req_ready, fill_valid, fill_data, fill_err
  );
endinterface

// File: rtl/l2mc_sat_cnt.sv
// Saturating up-counter with synchronous reset and increment enable.
module l2mc_sat_cnt #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  output logic [CW-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (inc && (cnt != '1))
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/l2_miss_ctrl.sv
// L2 miss sequencer in front of the ECC main memory: optional victim writeback, fill capture, L2 return.
// Define L2MC_RETRY_EN to re-read once after an uncorrectable first capture.
module l2_miss_ctrl
  import l2mc_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  l2_miss_ctrl_if.slave l2,
  output logic [CW-1:0] err_cnt,
  output logic          l2_miss,
  output logic          en_back,
  output logic [AW-1:0] group_id,
  inout  wire  [DW-1:0] data_block,
  input  logic          error_mem
);

  l2mc_state_e   state, state_nxt;
  logic          accept;
  logic          bus_oe;
  logic          cap_en;
  logic [AW-1:0] group_p0;
  logic          dirty_p0;
  logic [DW-1:0] wdata_p0;
  logic [DW-1:0] fill_data_p1;
  logic          fill_err_p1;
`ifdef L2MC_RETRY_EN
  logic          retry_p0;
  logic          gap_enter;
`endif

  assign accept = l2.req_valid && l2.req_ready;

  always_comb begin
    state_nxt = state;
    l2_miss   = 1'b0;
    en_back   = 1'b0;
    bus_oe    = 1'b0;
    cap_en    = 1'b0;
`ifdef L2MC_RETRY_EN
    gap_enter = 1'b0;
`endif
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        l2_miss   = 1'b1;
        en_back   = dirty_p0;
        bus_oe    = dirty_p0;
        state_nxt = dirty_p0 ? ST_RD : ST_CAP;
      end
      ST_RD:    state_nxt = ST_CAP;
      ST_CAP: begin
        cap_en    = 1'b1;
        state_nxt = ST_RSP;
`ifdef L2MC_RETRY_EN
        if (error_mem && !retry_p0) begin
          state_nxt = ST_GAP;
          gap_enter = 1'b1;
        end
`endif
      end
      ST_RSP:   if (l2.fill_ready) state_nxt = ST_IDLE;
`ifdef L2MC_RETRY_EN
      // GAP sits on the memory dead cycle so the re-issue cannot be ignored
      ST_GAP:   state_nxt = ST_ISSUE;
`endif
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Stage p0: request capture; stage p1: fill capture from the memory output cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      group_p0     <= '0;
      dirty_p0     <= 1'b0;
      fill_data_p1 <= '0;
      fill_err_p1  <= 1'b0;
`ifdef L2MC_RETRY_EN
      retry_p0     <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        group_p0 <= l2.req_group;
        dirty_p0 <= l2.req_dirty;
`ifdef L2MC_RETRY_EN
        retry_p0 <= 1'b0;
`endif
      end
      if (cap_en) begin
        fill_data_p1 <= data_block;
        fill_err_p1  <= error_mem;
      end
`ifdef L2MC_RETRY_EN
      // The retry is a plain read; the victim was already written back
      if (gap_enter) begin
        dirty_p0 <= 1'b0;
        retry_p0 <= 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      wdata_p0 <= l2.req_wdata;
  end

  l2mc_sat_cnt #(.CW(CW)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (cap_en && error_mem),
    .cnt   (err_cnt)
  );

  assign data_block    = bus_oe ? wdata_p0 : BUS_Z[DW-1:0];
  assign group_id      = group_p0;
  assign l2.req_ready  = (state == ST_IDLE);
  assign l2.fill_valid = (state == ST_RSP);
  assign l2.fill_data  = fill_data_p1;
  assign l2.fill_err   = fill_err_p1;

endmodule

// File: tb/tb_l2_miss_ctrl.sv
// Directed bench for l2_miss_ctrl with a behavioural ECC main-memory model on the shared bus.
module tb_l2_miss_ctrl;
  localparam int DW = 128;
  localparam int AW = 3;
  localparam int CW = 8;
`ifdef L2MC_RETRY_EN
  localparam int DBL_LAT = 6;
  localparam logic [CW-1:0] DBL_CNT = 8'd2;
`else
  localparam int DBL_LAT = 3;
  localparam logic [CW-1:0] DBL_CNT = 8'd1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  l2_miss_ctrl_if #(.DW(DW), .AW(AW)) l2 ();
  logic [CW-1:0] err_cnt;
  logic          l2_miss, en_back, error_mem;
  logic [AW-1:0] group_id;
  tri0  [DW-1:0] data_block;

  l2_miss_ctrl #(.DW(DW), .AW(AW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .l2(l2), .err_cnt(err_cnt), .l2_miss(l2_miss),
    .en_back(en_back), .group_id(group_id), .data_block(data_block), .error_mem(error_mem)
  );

  int n_assert = 0;
  int n_fail = 0;
  logic mon_en = 1'b0;
  logic [DW-1:0] cur_w = '0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int g);
    return {4{32'hC0DE_0000 + g}};
  endfunction

  // Memory model: stores clean lines; flip_mask injects stored-bit errors (1 bit corrected, 2+ flagged)
  logic [DW-1:0] dram [8];
  logic [DW-1:0] flip_mask [8];
  logic          dram_ok = 1'b0;
  logic          mem_oe = 1'b0, mem_dead = 1'b0, mem_pend = 1'b0;
  logic [AW-1:0] mem_grp = '0;
  logic [DW-1:0] mem_dout = '0;
  assign data_block = mem_oe ? mem_dout : {DW{1'bz}};

  always @(posedge clk) begin
    if (reset) begin
      mem_oe    <= 1'b0;
      mem_dead  <= 1'b0;
      mem_pend  <= 1'b0;
      error_mem <= 1'b0;
      if (!dram_ok) begin
        for (int i = 0; i < 8; i++) dram[i] <= pat(i);
        dram_ok <= 1'b1;
      end
    end else begin
      mem_dead  <= mem_oe;
      mem_oe    <= 1'b0;
      error_mem <= 1'b0;
      if (l2_miss && en_back) begin
        dram[group_id] <= data_block;
        mem_grp        <= group_id;
        mem_pend       <= 1'b1;
      end else if (l2_miss || mem_pend) begin
        automatic logic [AW-1:0] g = l2_miss ? group_id : mem_grp;
        automatic int nflip = $countones(flip_mask[g]);
        mem_pend  <= 1'b0;
        mem_oe    <= 1'b1;
        mem_dout  <= (nflip >= 2) ? (dram[g] ^ flip_mask[g]) : dram[g];
        error_mem <= (nflip >= 2);
      end
    end
  end

  // Continuous bus ownership and dead-cycle checks
  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_dead) chk("dead_cycle_l2_miss", {127'b0, l2_miss}, '0);
      if (mem_oe) chk("bus_mem_drive", data_block, mem_dout);
      else if (l2_miss && en_back) chk("bus_writeback", data_block, cur_w);
      else chk("bus_highz", data_block, '0);
      if (!l2_miss) chk("en_back_outside_issue", {127'b0, en_back}, '0);
    end
  end

  task automatic do_req(input logic [AW-1:0] g, input logic d, input logic [DW-1:0] w,
                        output int lat);
    chk("req_ready_idle", {127'b0, l2.req_ready}, 1);
    cur_w = w;
    l2.req_valid = 1'b1; l2.req_group = g; l2.req_dirty = d; l2.req_wdata = w;
    @(posedge clk); #1;
    l2.req_valid = 1'b0;
    chk("issue_l2_miss", {127'b0, l2_miss}, 1);
    chk("issue_en_back", {127'b0, en_back}, {127'b0, d});
    chk("issue_group_id", {125'b0, group_id}, {125'b0, g});
    lat = 1;
    while (!l2.fill_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take_fill();
    l2.fill_ready = 1'b1;
    @(posedge clk); #1;
    l2.fill_ready = 1'b0;
    chk("fill_valid_after_accept", {127'b0, l2.fill_valid}, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time exceeded, expected completion before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [DW-1:0] w1, w2;
    w1 = 128'h0123456789ABCDEF0123456789ABCDEF;
    w2 = 128'hFEDCBA9876543210FEDCBA9876543210;
    for (int i = 0; i < 8; i++) flip_mask[i] = '0;
    l2.req_valid = 1'b0; l2.req_group = '0; l2.req_dirty = 1'b0;
    l2.req_wdata = '0; l2.fill_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    mon_en = 1'b1;

    chk("rst_req_ready", {127'b0, l2.req_ready}, 1);
    chk("rst_fill_valid", {127'b0, l2.fill_valid}, '0);
    chk("rst_fill_err", {127'b0, l2.fill_err}, '0);
    chk("rst_fill_data", l2.fill_data, '0);
    chk("rst_err_cnt", {120'b0, err_cnt}, '0);
    chk("rst_l2_miss", {127'b0, l2_miss}, '0);
    chk("rst_group_id", {125'b0, group_id}, '0);
    chk("rst_bus_highz", data_block, '0);

    // Dirty writeback to group 5, then a clean read of the same group
    do_req(3'd5, 1'b1, w1, lat);
    chk("dirty_latency", lat, 4);
    chk("dirty_fill_data", l2.fill_data, w1);
    chk("dirty_fill_err", {127'b0, l2.fill_err}, '0);
    take_fill();
    do_req(3'd5, 1'b0, '0, lat);
    chk("clean_latency", lat, 3);
    chk("readback_data", l2.fill_data, w1);
    chk("readback_err", {127'b0, l2.fill_err}, '0);
    take_fill();

    // Single-bit error is corrected by memory
    flip_mask[2] = 128'h1 << 17;
    do_req(3'd2, 1'b0, '0, lat);
    chk("sbe_latency", lat, 3);
    chk("sbe_fill_data", l2.fill_data, pat(2));
    chk("sbe_fill_err", {127'b0, l2.fill_err}, '0);
    chk("sbe_err_cnt", {120'b0, err_cnt}, '0);
    take_fill();

    // Double-bit error is flagged
    flip_mask[3] = (128'h1 << 3) | (128'h1 << 100);
    do_req(3'd3, 1'b0, '0, lat);
    chk("dbe_latency", lat, DBL_LAT);
    chk("dbe_fill_data", l2.fill_data, pat(3) ^ flip_mask[3]);
    chk("dbe_fill_err", {127'b0, l2.fill_err}, 1);
    chk("dbe_err_cnt", {120'b0, err_cnt}, {120'b0, DBL_CNT});
    take_fill();

    // Backpressure with a competing request held on the input
    do_req(3'd1, 1'b0, '0, lat);
    chk("bp_latency", lat, 3);
    l2.req_valid = 1'b1; l2.req_group = 3'd6; l2.req_dirty = 1'b0;
    for (int c = 0; c < 10; c++) begin
      chk("bp_fill_valid", {127'b0, l2.fill_valid}, 1);
      chk("bp_fill_data", l2.fill_data, pat(1));
      chk("bp_group_id", {125'b0, group_id}, 128'd1);
      chk("bp_req_ready", {127'b0, l2.req_ready}, '0);
      @(posedge clk); #1;
    end
    l2.req_valid = 1'b0;
    take_fill();
    chk("bp_req_ready_after", {127'b0, l2.req_ready}, 1);

    // Back-to-back clean requests with fill_ready held high
    l2.req_valid = 1'b1; l2.req_group = 3'd0; l2.req_dirty = 1'b0; l2.fill_ready = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 5) l2.req_valid = 1'b0;
      chk($sformatf("b2b_l2_miss_c%0d", c), {127'b0, l2_miss}, {127'b0, (c == 1 || c == 5)});
      chk($sformatf("b2b_fill_valid_c%0d", c), {127'b0, l2.fill_valid},
          {127'b0, (c == 3 || c == 7)});
      if (c == 3 || c == 7) chk("b2b_fill_data", l2.fill_data, pat(0));
    end
    l2.fill_ready = 1'b0;

    // Reset asserted while the memory is in its writeback/read cycle
    cur_w = w2;
    l2.req_valid = 1'b1; l2.req_group = 3'd4; l2.req_dirty = 1'b1; l2.req_wdata = w2;
    @(posedge clk); #1;
    l2.req_valid = 1'b0;
    chk("rd_issue_en_back", {127'b0, en_back}, 1);
    @(posedge clk); #1;
    chk("rd_no_l2_miss", {127'b0, l2_miss}, '0);
    chk("rd_no_fill", {127'b0, l2.fill_valid}, '0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_req_ready", {127'b0, l2.req_ready}, 1);
    chk("mid_rst_fill_valid", {127'b0, l2.fill_valid}, '0);
    chk("mid_rst_bus_highz", data_block, '0);
    chk("mid_rst_err_cnt", {120'b0, err_cnt}, '0);
    chk("mid_rst_group_id", {125'b0, group_id}, '0);
    do_req(3'd7, 1'b0, '0, lat);
    chk("post_rst_latency", lat, 3);
    chk("post_rst_fill_data", l2.fill_data, pat(7));
    chk("post_rst_fill_err", {127'b0, l2.fill_err}, '0);
    take_fill();

    repeat (2) @(posedge clk);
    #1 mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
